// File: rtl/pmp_chk_stage.sv
// Per-requester PMP check slots with a fixed-priority access-fault trap arbiter.
// Optional PMP_FAULT_CNT_EN adds a saturating acked-fault counter.
module pmp_chk_stage #(
  parameter int REQ_CHANNEL_NUM = 3,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [REQ_CHANNEL_NUM-1:0]                  req_vld,
  output logic [REQ_CHANNEL_NUM-1:0]                  req_rdy,
  input  logic [REQ_CHANNEL_NUM-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [REQ_CHANNEL_NUM-1:0][1:0]             req_mode,
  output logic [REQ_CHANNEL_NUM-1:0][ADDR_WIDTH-1:0]  pmp_req_addr,
  output logic [REQ_CHANNEL_NUM-1:0][1:0]             pmp_req_mode,
  input  logic [REQ_CHANNEL_NUM-1:0]                  pmp_pass,
  output logic [REQ_CHANNEL_NUM-1:0]                  rsp_vld,
  output logic [REQ_CHANNEL_NUM-1:0]                  rsp_ok,
  input  logic [REQ_CHANNEL_NUM-1:0]                  rsp_rdy,
  output logic                                        trap_vld,
  output logic [3:0]                                  trap_cause,
  output logic [ADDR_WIDTH-1:0]                       trap_tval,
  input  logic                                        trap_ack,
`ifdef PMP_FAULT_CNT_EN
  output logic [15:0]                                 fault_cnt,
  input  logic                                        fault_cnt_clr,
`endif
  input  logic                                        flush
);

  localparam int N  = REQ_CHANNEL_NUM;
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CHK  = 2'd1,
    FLT  = 2'd2,
    RSPF = 2'd3
  } st_e;

  st_e                           st_q [N];
  st_e                           st_d [N];
  logic [N-1:0][ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [N-1:0][1:0]             mode_q, mode_d;
  logic [N-1:0]                  ok;

  logic                  trap_vld_q, trap_vld_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [3:0]            cause_q, cause_d;
  logic [ADDR_WIDTH-1:0] tval_q, tval_d;
  logic                  fnd;

  function automatic logic [3:0] cause_of(input logic [1:0] m);
    logic [3:0] c;
    c = 4'd0;
    unique case (m)
      2'b11:   c = 4'd1;
      2'b01:   c = 4'd5;
      2'b10:   c = 4'd7;
      default: c = 4'd0;
    endcase
    return c;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      st_d[i]    = st_q[i];
      addr_d[i]  = addr_q[i];
      mode_d[i]  = mode_q[i];
      req_rdy[i] = 1'b0;
      rsp_vld[i] = 1'b0;
      rsp_ok[i]  = 1'b0;
      ok[i]      = pmp_pass[i] | (mode_q[i] == 2'b00);
      unique case (st_q[i])
        IDLE: begin
          req_rdy[i] = !flush;
          if (req_vld[i] && !flush) begin
            addr_d[i] = req_addr[i];
            mode_d[i] = req_mode[i];
            st_d[i]   = CHK;
          end
        end
        CHK: begin
          rsp_vld[i] = ok[i];
          rsp_ok[i]  = ok[i];
          if (!ok[i]) begin
            st_d[i] = FLT;
          end else if (rsp_rdy[i]) begin
            req_rdy[i] = !flush;
            st_d[i]    = IDLE;
            // Reload in the response cycle for 1/cycle throughput
            if (req_vld[i] && !flush) begin
              addr_d[i] = req_addr[i];
              mode_d[i] = req_mode[i];
              st_d[i]   = CHK;
            end
          end
        end
        FLT: begin
          if (trap_vld_q && trap_ack && grant_q == GW'(i))
            st_d[i] = RSPF;
        end
        RSPF: begin
          rsp_vld[i] = 1'b1;
          if (rsp_rdy[i])
            st_d[i] = IDLE;
        end
        default: st_d[i] = IDLE;
      endcase
      if (flush)
        st_d[i] = IDLE;
    end
  end

  always_comb begin
    trap_vld_d = trap_vld_q;
    grant_d    = grant_q;
    cause_d    = cause_q;
    tval_d     = tval_q;
    fnd        = 1'b0;
    if (flush) begin
      trap_vld_d = 1'b0;
    end else if (trap_vld_q) begin
      if (trap_ack)
        trap_vld_d = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!fnd && st_q[i] == FLT) begin
          fnd        = 1'b1;
          trap_vld_d = 1'b1;
          grant_d    = GW'(i);
          cause_d    = cause_of(mode_q[i]);
          tval_d     = addr_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        st_q[i] <= IDLE;
      addr_q     <= '0;
      mode_q     <= '0;
      trap_vld_q <= 1'b0;
      grant_q    <= '0;
      cause_q    <= '0;
      tval_q     <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        st_q[i] <= st_d[i];
      addr_q     <= addr_d;
      mode_q     <= mode_d;
      trap_vld_q <= trap_vld_d;
      grant_q    <= grant_d;
      cause_q    <= cause_d;
      tval_q     <= tval_d;
    end
  end

  assign pmp_req_addr = addr_q;
  assign pmp_req_mode = mode_q;
  assign trap_vld     = trap_vld_q;
  assign trap_cause   = cause_q;
  assign trap_tval    = tval_q;

`ifdef PMP_FAULT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (fault_cnt_clr)
      cnt_d = 16'd0;
    else if (trap_vld_q && trap_ack && !flush && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= 16'd0;
    else
      cnt_q <= cnt_d;
  end

  assign fault_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pmp_chk_stage.sv
// Directed bench for pmp_chk_stage: pass path, throughput, faults,
// trap priority, flush and reset.
module tb_pmp_chk_stage;

  localparam int N  = 3;
  localparam int AW = 32;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N-1:0]          req_vld;
  logic [N-1:0]          req_rdy;
  logic [N-1:0][AW-1:0]  req_addr;
  logic [N-1:0][1:0]     req_mode;
  logic [N-1:0][AW-1:0]  pmp_req_addr;
  logic [N-1:0][1:0]     pmp_req_mode;
  logic [N-1:0]          pmp_pass;
  logic [N-1:0]          rsp_vld;
  logic [N-1:0]          rsp_ok;
  logic [N-1:0]          rsp_rdy;
  logic                  trap_vld;
  logic [3:0]            trap_cause;
  logic [AW-1:0]         trap_tval;
  logic                  trap_ack;
  logic                  flush;
`ifdef PMP_FAULT_CNT_EN
  logic [15:0]           fault_cnt;
  logic                  fault_cnt_clr;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pmp_chk_stage #(.REQ_CHANNEL_NUM(N), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_vld      (req_vld),
    .req_rdy      (req_rdy),
    .req_addr     (req_addr),
    .req_mode     (req_mode),
    .pmp_req_addr (pmp_req_addr),
    .pmp_req_mode (pmp_req_mode),
    .pmp_pass     (pmp_pass),
    .rsp_vld      (rsp_vld),
    .rsp_ok       (rsp_ok),
    .rsp_rdy      (rsp_rdy),
    .trap_vld     (trap_vld),
    .trap_cause   (trap_cause),
    .trap_tval    (trap_tval),
    .trap_ack     (trap_ack),
`ifdef PMP_FAULT_CNT_EN
    .fault_cnt    (fault_cnt),
    .fault_cnt_clr(fault_cnt_clr),
`endif
    .flush        (flush)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    req_vld  = '0;
    req_addr = '0;
    req_mode = '0;
    pmp_pass = '1;
    rsp_rdy  = '1;
    trap_ack = 1'b0;
    flush    = 1'b0;
`ifdef PMP_FAULT_CNT_EN
    fault_cnt_clr = 1'b0;
`endif
    tick();
    tick();
    chk("rst_req_rdy", 64'(req_rdy), 64'h7);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'h0);
    chk("rst_rsp_ok", 64'(rsp_ok), 64'h0);
    chk("rst_trap_vld", 64'(trap_vld), 64'h0);
    chk("rst_cause", 64'(trap_cause), 64'h0);
    chk("rst_tval", 64'(trap_tval), 64'h0);
    chk("rst_pmp_addr", 64'(pmp_req_addr), 64'h0);
    chk("rst_pmp_mode", 64'(pmp_req_mode), 64'h0);
`ifdef PMP_FAULT_CNT_EN
    chk("rst_fault_cnt", 64'(fault_cnt), 64'h0);
`endif
    rst_n = 1'b1;
    tick();

    // ch0 load pass
    req_vld     = 3'b001;
    req_addr[0] = 32'h8000_0000;
    req_mode[0] = 2'b01;
    tick();
    req_vld = '0;
    #1;
    chk("ld_pmp_addr", 64'(pmp_req_addr[0]), 64'h8000_0000);
    chk("ld_pmp_mode", 64'(pmp_req_mode[0]), 64'h1);
    chk("ld_rsp_vld", 64'(rsp_vld), 64'h1);
    chk("ld_rsp_ok", 64'(rsp_ok), 64'h1);
    chk("ld_no_trap", 64'(trap_vld), 64'h0);
    tick();
    chk("ld_done", 64'(rsp_vld), 64'h0);

    // ch1 back-to-back
    for (int i = 0; i < 4; i++) begin
      req_vld     = 3'b010;
      req_addr[1] = 32'h100 + 32'(i * 4);
      req_mode[1] = 2'b01;
      tick();
      chk("b2b_addr", 64'(pmp_req_addr[1]), 64'h100 + 64'(i * 4));
      chk("b2b_rsp_vld", 64'(rsp_vld), 64'h2);
      chk("b2b_req_rdy", 64'(req_rdy[1]), 64'h1);
    end
    req_vld = '0;
    tick();
    chk("b2b_done", 64'(rsp_vld), 64'h0);

    // pass response held while !rsp_rdy
    req_vld     = 3'b010;
    req_addr[1] = 32'h200;
    req_mode[1] = 2'b10;
    rsp_rdy     = 3'b000;
    tick();
    req_vld = '0;
    #1;
    chk("hold_rsp_vld", 64'(rsp_vld), 64'h2);
    chk("hold_req_rdy", 64'(req_rdy[1]), 64'h0);
    tick();
    chk("hold_rsp_vld2", 64'(rsp_vld), 64'h2);
    chk("hold_rsp_ok2", 64'(rsp_ok), 64'h2);
    rsp_rdy = '1;
    tick();
    chk("hold_done", 64'(rsp_vld), 64'h0);

    // ch2 fetch fault
    pmp_pass    = 3'b011;
    req_vld     = 3'b100;
    req_addr[2] = 32'h0000_1000;
    req_mode[2] = 2'b11;
    tick();
    req_vld = '0;
    #1;
    chk("ft_chk_no_rsp", 64'(rsp_vld), 64'h0);
    tick();
    chk("ft_t1_no_trap", 64'(trap_vld), 64'h0);
    tick();
    chk("ft_trap_vld", 64'(trap_vld), 64'h1);
    chk("ft_cause", 64'(trap_cause), 64'h1);
    chk("ft_tval", 64'(trap_tval), 64'h1000);
    chk("ft_no_rsp", 64'(rsp_vld), 64'h0);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    #1;
    chk("ft_trap_drop", 64'(trap_vld), 64'h0);
    chk("ft_rspf_vld", 64'(rsp_vld), 64'h4);
    chk("ft_rspf_ok", 64'(rsp_ok), 64'h0);
    tick();
    chk("ft_done_rsp", 64'(rsp_vld), 64'h0);
    chk("ft_done_trap", 64'(trap_vld), 64'h0);

    // ch0 store and ch2 load fail together
    pmp_pass    = 3'b010;
    req_vld     = 3'b101;
    req_addr[0] = 32'h2000;
    req_mode[0] = 2'b10;
    req_addr[2] = 32'h3000;
    req_mode[2] = 2'b01;
    tick();
    req_vld = '0;
    tick();
    tick();
    chk("pri_trap0", 64'(trap_vld), 64'h1);
    chk("pri_cause0", 64'(trap_cause), 64'h7);
    chk("pri_tval0", 64'(trap_tval), 64'h2000);
    tick();
    chk("pri_stable_cause", 64'(trap_cause), 64'h7);
    chk("pri_stable_tval", 64'(trap_tval), 64'h2000);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    #1;
    chk("pri_gap", 64'(trap_vld), 64'h0);
    chk("pri_rsp0", 64'(rsp_vld), 64'h1);
    tick();
    chk("pri_trap2", 64'(trap_vld), 64'h1);
    chk("pri_cause2", 64'(trap_cause), 64'h5);
    chk("pri_tval2", 64'(trap_tval), 64'h3000);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    #1;
    chk("pri_rsp2", 64'(rsp_vld), 64'h4);
    chk("pri_rsp2_ok", 64'(rsp_ok), 64'h0);
    tick();
`ifdef PMP_FAULT_CNT_EN
    chk("cnt_three", 64'(fault_cnt), 64'h3);
`endif

    // flush with trap_ack
    pmp_pass    = 3'b000;
    req_vld     = 3'b010;
    req_addr[1] = 32'h4000;
    req_mode[1] = 2'b11;
    tick();
    req_vld = '0;
    tick();
    tick();
    chk("fl_trap_up", 64'(trap_vld), 64'h1);
    flush    = 1'b1;
    trap_ack = 1'b1;
    req_vld  = 3'b001;
    #1;
    chk("fl_req_rdy", 64'(req_rdy), 64'h0);
    tick();
    flush    = 1'b0;
    trap_ack = 1'b0;
    req_vld  = '0;
    #1;
    chk("fl_trap_drop", 64'(trap_vld), 64'h0);
    chk("fl_no_rsp", 64'(rsp_vld), 64'h0);
    chk("fl_idle_rdy", 64'(req_rdy), 64'h7);
    tick();
    chk("fl_no_retrap", 64'(trap_vld), 64'h0);
    chk("fl_no_rsp2", 64'(rsp_vld), 64'h0);
`ifdef PMP_FAULT_CNT_EN
    chk("cnt_flush_ack", 64'(fault_cnt), 64'h3);
`endif

    // mode 00 never faults
    req_vld     = 3'b001;
    req_addr[0] = 32'h5000;
    req_mode[0] = 2'b00;
    tick();
    req_vld = '0;
    #1;
    chk("nochk_rsp_vld", 64'(rsp_vld), 64'h1);
    chk("nochk_rsp_ok", 64'(rsp_ok), 64'h1);
    tick();
    tick();
    chk("nochk_no_trap", 64'(trap_vld), 64'h0);

`ifdef PMP_FAULT_CNT_EN
    req_vld     = 3'b001;
    req_addr[0] = 32'h6000;
    req_mode[0] = 2'b01;
    tick();
    req_vld = '0;
    tick();
    tick();
    chk("clr_trap_up", 64'(trap_vld), 64'h1);
    trap_ack      = 1'b1;
    fault_cnt_clr = 1'b1;
    tick();
    trap_ack      = 1'b0;
    fault_cnt_clr = 1'b0;
    #1;
    chk("cnt_clr_wins", 64'(fault_cnt), 64'h0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
